data_cache_port0_arbiter: RTL and testbench



---
 rtl/data_cache_port0_arbiter.sv | 105 ++++++++++
 tb/tb_data_cache_port0_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_cache_port0_arbiter.sv
// rtl/data_cache_port0_arbiter.sv - port 0 owner arbiter for STU, LDU and INV with aging counters
module data_cache_port0_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       stu_request_i,
  input  logic       ldu_request_i,
  input  logic       inv_request_i,
  output logic       stu_grant_o,
  output logic       ldu_grant_o,
  output logic       inv_grant_o,
  output logic [1:0] port_select_o,
  output logic       port_busy_o,
  output logic       stu_starved_o,
  output logic       ldu_starved_o
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  // Encoding doubles as the port 0 mux select.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN_STU = 2'b01,
    OWN_LDU = 2'b10,
    OWN_INV = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] stu_cnt_q, stu_cnt_d;
  logic [WAIT_W-1:0] ldu_cnt_q, ldu_cnt_d;
  logic              owner_holds;
  logic              stu_starved;
  logic              ldu_starved;

  assign stu_starved = (stu_cnt_q == MAX_CNT);
  assign ldu_starved = (ldu_cnt_q == MAX_CNT);

  always_comb begin
    state_d     = state_q;
    owner_holds = 1'b0;
    unique case (state_q)
      OWN_STU: owner_holds = stu_request_i;
      OWN_LDU: owner_holds = ldu_request_i;
      OWN_INV: owner_holds = inv_request_i;
      default: owner_holds = 1'b0;
    endcase

    if (!owner_holds) begin
      if (stu_request_i && stu_starved) begin
        state_d = OWN_STU;
      end else if (ldu_request_i && ldu_starved) begin
        state_d = OWN_LDU;
      end else if (inv_request_i) begin
        state_d = OWN_INV;
      end else if (stu_request_i) begin
        state_d = OWN_STU;
      end else if (ldu_request_i) begin
        state_d = OWN_LDU;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Clearing on the next owner makes the counter read 0 when its grant appears.
  always_comb begin
    stu_cnt_d = stu_cnt_q;
    ldu_cnt_d = ldu_cnt_q;

    if (!stu_request_i || (state_d == OWN_STU)) begin
      stu_cnt_d = '0;
    end else if (!stu_starved) begin
      stu_cnt_d = stu_cnt_q + 1'b1;
    end

    if (!ldu_request_i || (state_d == OWN_LDU)) begin
      ldu_cnt_d = '0;
    end else if (!ldu_starved) begin
      ldu_cnt_d = ldu_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      stu_cnt_q <= '0;
      ldu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      stu_cnt_q <= stu_cnt_d;
      ldu_cnt_q <= ldu_cnt_d;
    end
  end

  assign stu_grant_o   = (state_q == OWN_STU);
  assign ldu_grant_o   = (state_q == OWN_LDU);
  assign inv_grant_o   = (state_q == OWN_INV);
  assign port_select_o = state_q;
  assign port_busy_o   = (state_q != IDLE);
  assign stu_starved_o = stu_starved;
  assign ldu_starved_o = ldu_starved;

endmodule

// File: tb/tb_data_cache_port0_arbiter.sv
// tb/tb_data_cache_port0_arbiter.sv - directed bench with an ownership model for the port 0 arbiter
module tb_data_cache_port0_arbiter;

  localparam int MAX_WAIT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stu_req, ldu_req, inv_req;
  logic       stu_gnt, ldu_gnt, inv_gnt;
  logic [1:0] sel;
  logic       busy;
  logic       stu_stv, ldu_stv;

  int n_checks = 0;
  int n_errors = 0;

  // Owner: 0 none, 1 STU, 2 LDU, 3 INV; ages count waiting cycles.
  int m_owner = 0;
  int m_age_stu = 0;
  int m_age_ldu = 0;

  always #5 clk = ~clk;

  data_cache_port0_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stu_request_i (stu_req),
    .ldu_request_i (ldu_req),
    .inv_request_i (inv_req),
    .stu_grant_o   (stu_gnt),
    .ldu_grant_o   (ldu_gnt),
    .inv_grant_o   (inv_gnt),
    .port_select_o (sel),
    .port_busy_o   (busy),
    .stu_starved_o (stu_stv),
    .ldu_starved_o (ldu_stv)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int pick_owner(int own, bit s, bit l, bit i, int as, int al);
    bit req[4];
    req = '{1'b0, s, l, i};
    if (own != 0 && req[own]) return own;
    if (s && as >= MAX_WAIT) return 1;
    if (l && al >= MAX_WAIT) return 2;
    if (i) return 3;
    if (s) return 1;
    if (l) return 2;
    return 0;
  endfunction

  function automatic int age(bit req, bit wins, int cur);
    if (!req || wins) return 0;
    return (cur + 1 > MAX_WAIT) ? MAX_WAIT : cur + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner   <= 0;
      m_age_stu <= 0;
      m_age_ldu <= 0;
    end else begin
      m_owner   <= pick_owner(m_owner, stu_req, ldu_req, inv_req, m_age_stu, m_age_ldu);
      m_age_stu <= age(stu_req, pick_owner(m_owner, stu_req, ldu_req, inv_req, m_age_stu, m_age_ldu) == 1, m_age_stu);
      m_age_ldu <= age(ldu_req, pick_owner(m_owner, stu_req, ldu_req, inv_req, m_age_stu, m_age_ldu) == 2, m_age_ldu);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("model_stu_grant", {3'b0, stu_gnt}, {3'b0, m_owner == 1});
      check("model_ldu_grant", {3'b0, ldu_gnt}, {3'b0, m_owner == 2});
      check("model_inv_grant", {3'b0, inv_gnt}, {3'b0, m_owner == 3});
      check("model_select", {2'b0, sel}, 4'(m_owner));
      check("model_busy", {3'b0, busy}, {3'b0, m_owner != 0});
      check("model_stu_starved", {3'b0, stu_stv}, {3'b0, m_age_stu == MAX_WAIT});
      check("model_ldu_starved", {3'b0, ldu_stv}, {3'b0, m_age_ldu == MAX_WAIT});
    end
  end

  initial begin
    rst_n = 1'b0;
    stu_req = 1'b1; ldu_req = 1'b1; inv_req = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, sel, stu_gnt | ldu_gnt | inv_gnt}, 4'd0);
    check("reset_starved", {2'b0, stu_stv, ldu_stv}, 4'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_inv_grant", {3'b0, inv_gnt}, 4'd1);
    check("first_select", {2'b0, sel}, 4'd3);

    @(negedge clk); stu_req = 0; ldu_req = 0; inv_req = 0;
    repeat (2) @(negedge clk);

    // STU beats LDU from IDLE, then hands over without a bubble.
    stu_req = 1; ldu_req = 1;
    @(posedge clk); #1;
    check("stu_wins_idle", {2'b0, stu_gnt, ldu_gnt}, 4'b0010);
    repeat (3) @(negedge clk);
    stu_req = 0;
    @(posedge clk); #1;
    check("handover_ldu", {2'b0, stu_gnt, ldu_gnt}, 4'b0001);
    check("handover_busy", {3'b0, busy}, 4'd1);
    @(negedge clk); ldu_req = 0;
    @(negedge clk);

    // Owner holds while INV waits.
    stu_req = 1;
    @(negedge clk); inv_req = 1;
    repeat (15) @(negedge clk);
    check("hold_stu", {2'b0, stu_gnt, inv_gnt}, 4'b0010);
    stu_req = 0;
    @(posedge clk); #1;
    check("hold_release_inv", {2'b0, stu_gnt, inv_gnt}, 4'b0001);
    @(negedge clk); inv_req = 0;
    @(negedge clk);

    // LDU ages while INV then STU own the port.
    ldu_req = 1; inv_req = 1;
    repeat (4) @(negedge clk);
    check("ldu_not_yet_starved", {3'b0, ldu_stv}, 4'd0);
    inv_req = 0; stu_req = 1;
    repeat (5) @(negedge clk);
    inv_req = 1;
    @(negedge clk);
    check("ldu_starved", {3'b0, ldu_stv}, 4'd1);
    stu_req = 0;
    @(posedge clk); #1;
    check("starved_ldu_wins", {1'b0, ldu_gnt, inv_gnt, stu_gnt}, 4'b0100);
    check("ldu_starved_cleared", {3'b0, ldu_stv}, 4'd0);
    @(negedge clk); ldu_req = 0;
    @(negedge clk); inv_req = 0;
    @(negedge clk);

    // Both starved behind INV: STU first, LDU next, LDU stays starved meanwhile.
    inv_req = 1;
    @(negedge clk); stu_req = 1; ldu_req = 1;
    repeat (9) @(negedge clk);
    check("both_starved", {2'b0, stu_stv, ldu_stv}, 4'b0011);
    inv_req = 0;
    @(posedge clk); #1;
    check("starved_stu_first", {1'b0, stu_gnt, ldu_gnt, inv_gnt}, 4'b0100);
    check("ldu_still_starved", {2'b0, stu_stv, ldu_stv}, 4'b0001);
    @(negedge clk); stu_req = 0;
    @(posedge clk); #1;
    check("starved_ldu_next", {2'b0, stu_gnt, ldu_gnt}, 4'b0001);

    // Asynchronous reset mid-grant with a starved waiter.
    @(negedge clk); stu_req = 1;
    repeat (9) @(negedge clk);
    check("pre_reset_state", {1'b0, ldu_gnt, stu_stv, busy}, 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_grants", {1'b0, stu_gnt, ldu_gnt, inv_gnt}, 4'd0);
    check("async_reset_port", {1'b0, busy, sel}, 4'd0);
    check("async_reset_starved", {2'b0, stu_stv, ldu_stv}, 4'd0);
    ldu_req = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_stu", {2'b0, sel}, 4'd1);
    @(negedge clk); stu_req = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
